data_memory_ctrl: RTL
=====================

# data_memory_ctrl

Parametrised, byte-addressable data memory controller for the 32-bit core's MEM stage. It stores DEPTH 32-bit words in big-endian byte order and serves byte, halfword and word loads with sign or zero extension, plus byte, halfword and word stores. Requests use a valid/ready handshake, and read data returns through a registered response. Accesses that cross a word boundary are split into two internal beats by a small FSM.

## Interface
- DEPTH, 256: number of 32-bit words; must be a power of two, at least 4.
- ADDR_W, 32: byte-address width.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- wr_en  in  1  1 = store, 0 = load; sampled on accept.
- addr  in  ADDR_W  byte address.
- mem_acc_mode  in  3  access mode:
  - 000 BYTE, 001 HALFWORD, 010 WORD, 100 BYTE_UNSIGNED, 101 HALFWORD_UNSIGNED.
  - All other codes are illegal.
- wdata  in  32  store data; the low bytes are used for BYTE and HALFWORD stores.
- resp_valid  out  1  one-cycle pulse marking completion of the accepted request.
- rdata  out  32  load result; 0 for stores and errors.
- err  out  1  qualified by resp_valid: illegal mode, out-of-range address, or misaligned access with splitting disabled.

## Operation
- Memory layout:
  - Storage is mem[0:DEPTH-1], 32 bits per word, contents not reset.
  - Word index = addr[log2(DEPTH)+1:2]; byte offset = addr[1:0].
  - Offset 0 maps to bits [31:24] and offset 3 to bits [7:0] (big-endian).
- Accept condition: req_valid && req_ready. Every field is captured at accept.
- FSM states:
  - IDLE: req_ready=1. An aligned or in-word access completes at the accept edge. A crossing access goes to SPLIT.
  - SPLIT: req_ready=0. Performs the word index+1 beat, then returns to IDLE.
- Crossing definition: byte offset + size > 4, where size is 1, 2 or 4. Examples: halfword at offset 3; word at offset 1, 2 or 3.
- Loads:
  - Bytes are assembled MSB-first from the lowest address.
  - BYTE and HALFWORD sign-extend from bit 7 or bit 15.
  - The _UNSIGNED modes zero-extend. WORD returns all 32 bits.
- Stores:
  - Only the addressed bytes are written; the other bytes of the word are preserved.
  - The first beat writes the bytes in word i; the SPLIT beat writes the bytes in word i+1.
- Error checks, evaluated at accept:
  - Illegal mode, or a store in an _UNSIGNED mode, is an error.
  - Any touched byte with word index >= DEPTH, or address bits above the memory range that are nonzero, is an error.
  - An errored request never writes memory, never enters SPLIT, and returns rdata=0, err=1.

## Timing
- Reset values: resp_valid=0, rdata=0, err=0, state=IDLE, req_ready=1.
- Latency:
  - Non-split access accepted at edge T: resp_valid high in cycle T+1.
  - Split access: resp_valid in cycle T+2, with req_ready=0 during cycle T+1.
- Throughput: one non-split request per cycle. A new request may be accepted in the same cycle as resp_valid.
- Memory ordering:
  - A store writes memory at its accept edge (split: the second word at the next edge).
  - A load accepted the cycle after a store to the same bytes returns the new data; there is no stale-read window.
- Outputs: rdata and err are registered and hold their value until the next resp_valid; resp_valid is low otherwise.
- Reset during SPLIT: FSM returns to IDLE with no response. A first-beat store that has already been written stays written.

## Configuration
- DMEM_MISALIGN_SPLIT_EN defined: crossing accesses use the SPLIT state as described above.
- DMEM_MISALIGN_SPLIT_EN undefined:
  - Any access with addr not naturally aligned to its size is rejected: resp_valid at T+1 with err=1, rdata=0, no write.
  - The SPLIT state is not built, and req_ready is tied to 1.
  - Aligned accesses behave identically in both builds.

## Test plan
- Reset: hold rst_n=0 for 3 cycles -> resp_valid=0, rdata=0, err=0, req_ready=1.
- Word round trip: store WORD 0xDEADBEEF at addr 0x10, then load BYTE at 0x10 and BYTE_UNSIGNED at 0x13 -> loads return 0xFFFFFFDE then 0x000000EF. Each resp_valid arrives 1 cycle after its accept, back-to-back.
- Halfword merge: word 0x20 holds 0x11223344; store HALFWORD 0x0000ABCD at 0x22; load WORD 0x20 -> 0x1122ABCD. Load HALFWORD at 0x22 -> 0xFFFFABCD; HALFWORD_UNSIGNED at 0x22 -> 0x0000ABCD.
- Split (macro defined): store WORD 0xCAFEF00D at 0x31; load WORD at 0x31 -> req_ready low for 1 cycle per access, resp_valid at T+2, rdata=0xCAFEF00D. Word 0x30 byte 0 and word 0x34 bytes 1-3 are unchanged.
- Errors: load with mode 3'b011 -> err=1, rdata=0. Store WORD at byte address 4*DEPTH -> err=1, and memory is unchanged on readback. With the macro undefined, load WORD at 0x31 -> err=1 at T+1.
- Reset mid-split: assert rst_n=0 in the SPLIT cycle of a crossing store at 0x3E -> no resp_valid, req_ready=1 after release. Word 0x3C holds the first-beat bytes; word 0x40 is unchanged.

Source files
------------

// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the MEM stage and the data memory controller.
// The core drives the master side; the controller implements the slave side.
interface data_memory_ctrl_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        mem_acc_mode;
  logic [31:0]       wdata;
  logic              resp_valid;
  logic [31:0]       rdata;
  logic              err;

  modport master (
    output req_valid, wr_en, addr, mem_acc_mode, wdata,
    input  req_ready, resp_valid, rdata, err
  );

  modport slave (
    input  req_valid, wr_en, addr, mem_acc_mode, wdata,
    output req_ready, resp_valid, rdata, err
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Big-endian byte-addressable data memory with a registered response.
// Define DMEM_MISALIGN_SPLIT_EN to split word-crossing accesses into two beats.
//
// state   | meaning
// S_IDLE  | ready; in-word accesses finish at the accept edge
// S_SPLIT | busy; second-word beat of a crossing access
module data_memory_ctrl #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  data_memory_ctrl_if.slave     bus
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [31:0]      r_mem [DEPTH];

  logic             r_resp_valid;
  logic [31:0]      r_rdata;
  logic             r_err;

  logic [IDX_W-1:0] r_idx1;
  logic [1:0]       r_off;
  logic [2:0]       r_size;
  logic             r_signed;
  logic             r_wr;
  logic [31:0]      r_word0;
  logic [31:0]      r_st_lo_data;
  logic [3:0]       r_st_lo_mask;

  logic             w_req_ready;
  logic             w_in_split;
  logic             w_go_split;
  logic             w_accept;
  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_off;
  logic [2:0]       w_size;
  logic             w_mode_err;
  logic             w_range_err;
  logic             w_align_err;
  logic             w_err;
  logic [3:0]       w_mask_lj;
  logic [7:0]       w_mask8;
  logic [31:0]      w_st_lj;
  logic [63:0]      w_st_win;
  logic [31:0]      w_rd0;
  logic [31:0]      w_rd1;
  logic             w_we;
  logic [IDX_W-1:0] w_widx;
  logic [31:0]      w_wword;
  logic [3:0]       w_wmask;

  function automatic logic [31:0] f_load(input logic [63:0] win, input logic [1:0] off,
                                         input logic [2:0] size, input logic sgn);
    logic [63:0] sh;
    logic [31:0] rj;
    sh = win << (8 * off);
    rj = sh[63:32] >> (8 * (4 - size));
    case (size)
      3'd1:    f_load = sgn ? {{24{rj[7]}}, rj[7:0]}   : {24'b0, rj[7:0]};
      3'd2:    f_load = sgn ? {{16{rj[15]}}, rj[15:0]} : {16'b0, rj[15:0]};
      default: f_load = rj;
    endcase
  endfunction

  assign w_accept = bus.req_valid && w_req_ready;
  assign w_idx    = bus.addr[IDX_W+1:2];
  assign w_off    = bus.addr[1:0];

  always_comb begin
    w_size    = 3'd4;
    w_mask_lj = 4'b1111;
    case (bus.mem_acc_mode[1:0])
      2'b00: begin w_size = 3'd1; w_mask_lj = 4'b1000; end
      2'b01: begin w_size = 3'd2; w_mask_lj = 4'b1100; end
      default: ;
    endcase
  end

  assign w_mode_err  = (bus.mem_acc_mode[1:0] == 2'b11)
                     || (bus.mem_acc_mode[2] && bus.mem_acc_mode[1])
                     || (bus.wr_en && bus.mem_acc_mode[2]);
  assign w_range_err = (bus.addr >> (IDX_W + 2)) != '0;
  assign w_err       = w_mode_err || w_range_err || w_align_err;

`ifdef DMEM_MISALIGN_SPLIT_EN
  typedef enum logic {S_IDLE, S_SPLIT} state_t;
  state_t r_state, w_state_nxt;
  logic   w_cross;

  assign w_cross     = (({1'b0, w_off} + w_size) > 3'd4);
  // The second beat of a crossing access at the last word would fall off the end.
  assign w_align_err = w_cross && (w_idx == {IDX_W{1'b1}});
  assign w_go_split  = w_accept && !w_err && w_cross;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b1;
    w_in_split  = 1'b0;
    case (r_state)
      S_IDLE:  if (w_go_split) w_state_nxt = S_SPLIT;
      S_SPLIT: begin
        w_req_ready = 1'b0;
        w_in_split  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end
`else
  assign w_align_err = ((w_size == 3'd2) && w_off[0]) || ((w_size == 3'd4) && (w_off != 2'd0));
  assign w_go_split  = 1'b0;
  assign w_req_ready = 1'b1;
  assign w_in_split  = 1'b0;
`endif

  // Store data and byte mask laid out over a two-word window, byte 0 in the MSBs.
  assign w_st_lj  = bus.wdata << (8 * (4 - w_size));
  assign w_st_win = {w_st_lj, 32'b0} >> (8 * w_off);
  assign w_mask8  = {w_mask_lj, 4'b0} >> w_off;

  assign w_rd0 = r_mem[w_idx];
  assign w_rd1 = r_mem[r_idx1];

  assign w_we    = i_rst_n && ((w_accept && !w_err && bus.wr_en) || (w_in_split && r_wr));
  assign w_widx  = w_in_split ? r_idx1       : w_idx;
  assign w_wword = w_in_split ? r_st_lo_data : w_st_win[63:32];
  assign w_wmask = w_in_split ? r_st_lo_mask : w_mask8[7:4];

  always_ff @(posedge i_clk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wmask[3-b]) r_mem[w_widx][31-8*b -: 8] <= w_wword[31-8*b -: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_resp_valid <= 1'b0;
      r_rdata      <= 32'b0;
      r_err        <= 1'b0;
      r_idx1       <= '0;
      r_off        <= 2'd0;
      r_size       <= 3'd4;
      r_signed     <= 1'b0;
      r_wr         <= 1'b0;
      r_word0      <= 32'b0;
      r_st_lo_data <= 32'b0;
      r_st_lo_mask <= 4'b0;
    end else begin
      r_resp_valid <= 1'b0;
      if (w_in_split) begin
        r_resp_valid <= 1'b1;
        r_err        <= 1'b0;
        r_rdata      <= r_wr ? 32'b0 : f_load({r_word0, w_rd1}, r_off, r_size, r_signed);
      end else if (w_accept) begin
        r_idx1       <= w_idx + 1'b1;
        r_off        <= w_off;
        r_size       <= w_size;
        r_signed     <= !bus.mem_acc_mode[2];
        r_wr         <= bus.wr_en;
        r_word0      <= w_rd0;
        r_st_lo_data <= w_st_win[31:0];
        r_st_lo_mask <= w_mask8[3:0];
        if (!w_go_split) begin
          r_resp_valid <= 1'b1;
          r_err        <= w_err;
          r_rdata      <= (w_err || bus.wr_en) ? 32'b0
                        : f_load({w_rd0, 32'b0}, w_off, w_size, !bus.mem_acc_mode[2]);
        end
      end
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.rdata      = r_rdata;
  assign bus.err        = r_err;
endmodule
